// File: rtl/mdu_seq_if.sv
// Issue/result bundle between the execute-stage controller and the iterative mult/div unit.
interface mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic             cancel;
  logic [WIDTH-1:0] Read_data_1;
  logic [WIDTH-1:0] Read_data_2;
  logic [WIDTH-1:0] HI_result;
  logic [WIDTH-1:0] LO_result;
  logic             busy;
  logic             done;

  modport master (
    output start, op, cancel, Read_data_1, Read_data_2,
    input  HI_result, LO_result, busy, done
  );

  modport slave (
    input  start, op, cancel, Read_data_1, Read_data_2,
    output HI_result, LO_result, busy, done
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative multiply/divide with HI/LO: one shift-add or restoring shift-subtract step per clock.
// Latency WIDTH+1 cycles from accept to done; start is ignored while busy, cancel squashes a running op.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input logic      clock,
  input logic      reset,
  mdu_seq_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             neg_q;
  logic             rneg_q;
  logic             dbz_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   madd;
  logic [WIDTH:0]   dshift;
  logic [WIDTH:0]   dsub;
  logic [WIDTH-1:0] acc_hi_d;
  logic [WIDTH-1:0] acc_lo_d;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  always_comb begin
    accept    = bus.start && !bus.cancel && (state_q != RUN);
    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_neg     = signed_op && bus.Read_data_1[WIDTH-1];
    b_neg     = signed_op && bus.Read_data_2[WIDTH-1];
    a_mag     = a_neg ? -bus.Read_data_1 : bus.Read_data_1;
    b_mag     = b_neg ? -bus.Read_data_2 : bus.Read_data_2;
  end

  // Multiply: acc_lo holds the multiplier shifting out as product bits shift in.
  // Divide: acc_lo holds the dividend shifting out as quotient bits shift in.
  always_comb begin
    madd   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    dshift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    dsub   = dshift - {1'b0, opnd_q};
    if (is_div_q) begin
      acc_hi_d = dsub[WIDTH] ? dshift[WIDTH-1:0] : dsub[WIDTH-1:0];
      acc_lo_d = {acc_lo_q[WIDTH-2:0], ~dsub[WIDTH]};
    end else begin
      acc_hi_d = madd[WIDTH:1];
      acc_lo_d = {madd[0], acc_lo_q[WIDTH-1:1]};
    end
    prod = {acc_hi_d, acc_lo_d};
    if (neg_q) prod = -prod;
    // A zero divisor leaves the remainder equal to |dividend|, so sign-correcting it restores the raw dividend.
    if (is_div_q) begin
      lo_d = dbz_q ? '1 : (neg_q ? -acc_lo_d : acc_lo_d);
      hi_d = rneg_q ? -acc_hi_d : acc_hi_d;
    end else begin
      lo_d = prod[WIDTH-1:0];
      hi_d = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (accept) begin
            case (bus.op)
              OP_MTHI: hi_q <= bus.Read_data_1;
              OP_MTLO: lo_q <= bus.Read_data_1;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div_q <= bus.op[1];
                opnd_q   <= bus.op[1] ? b_mag : a_mag;
                acc_lo_q <= bus.op[1] ? a_mag : b_mag;
                acc_hi_q <= '0;
                neg_q    <= a_neg ^ b_neg;
                rneg_q   <= a_neg;
                dbz_q    <= bus.op[1] && (bus.Read_data_2 == '0);
                cnt_q    <= '0;
                state_q  <= RUN;
                busy_q   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (bus.cancel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              hi_q    <= hi_d;
              lo_q    <= lo_d;
              cnt_q   <= '0;
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HI_result = hi_q;
  assign bus.LO_result = lo_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
